// File: rtl/soc_ctrl_rst_seq.sv
// Boot/software reset sequencer: releases per-domain resets and clock enables in order.
// Optional macro SOC_CTRL_RST_SEQ_DONE_PULSE_EN adds the sw_rst_done_o completion pulses.
module soc_ctrl_rst_seq #(
  parameter int NUM_DOMAINS = 4,
  parameter int RELEASE_GAP = 16,
  parameter int CLK_EN_LAG  = 8,
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   ref_clk_i,
  input  logic                   glb_arst_ni,
  input  logic                   start_i,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] domain_arst_no,
  output logic [NUM_DOMAINS-1:0] domain_clk_en_o,
  output logic                   boot_done_o,
  output logic                   busy_o,
  output logic [IW-1:0]          cur_domain_o
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
  ,
  output logic [NUM_DOMAINS-1:0] sw_rst_done_o
`endif
);

  // Zero-length gaps behave as one cycle.
  localparam int GAP_E = (RELEASE_GAP < 1) ? 1 : RELEASE_GAP;
  localparam int LAG_E = (CLK_EN_LAG < 1) ? 1 : CLK_EN_LAG;
  localparam int MAXV  = (GAP_E > LAG_E) ? GAP_E : LAG_E;
  localparam int CW    = $clog2(MAXV + 1);
  localparam logic [CW-1:0] GAP_TC = CW'(GAP_E - 1);
  localparam logic [CW-1:0] LAG_TC = CW'(LAG_E - 1);
  localparam logic [IW-1:0] LAST   = IW'(NUM_DOMAINS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] B_GAP  = 3'd1;
  localparam logic [2:0] B_LAG  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_OFF  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;
  localparam logic [2:0] S_LAG  = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] arst_q, arst_d;
  logic [NUM_DOMAINS-1:0] clken_q, clken_d;
  logic [NUM_DOMAINS-1:0] pend_q, pend_d, pend_clr;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [IW-1:0]          pick;
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
  logic [NUM_DOMAINS-1:0] pulse_q, pulse_d;
`endif

  function automatic logic [IW-1:0] lowest_set(input logic [NUM_DOMAINS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IW'(i);
    end
  endfunction

  assign pick = lowest_set(pend_q);

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    arst_d   = arst_q;
    clken_d  = clken_q;
    done_d   = done_q;
    busy_d   = busy_q;
    pend_clr = '0;
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
    pulse_d  = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = B_GAP;
          cnt_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      B_GAP: begin
        if (cnt_q == GAP_TC) begin
          arst_d[idx_q] = 1'b1;
          state_d       = B_LAG;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_LAG: begin
        if (cnt_q == LAG_TC) begin
          clken_d[idx_q] = 1'b1;
          cnt_d          = '0;
          if (idx_q == LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = B_GAP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (pend_q != '0) begin
          idx_d         = pick;
          pend_clr[pick] = 1'b1;
          clken_d[pick] = 1'b0;
          state_d       = S_OFF;
          cnt_d         = '0;
          busy_d        = 1'b1;
        end else begin
          idx_d  = '0;
          busy_d = 1'b0;
        end
      end
      S_OFF: begin
        if (cnt_q == LAG_TC) begin
          arst_d[idx_q] = 1'b0;
          state_d       = S_HOLD;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == GAP_TC) begin
          arst_d[idx_q] = 1'b1;
          state_d       = S_LAG;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LAG: begin
        if (cnt_q == LAG_TC) begin
          clken_d[idx_q] = 1'b1;
          cnt_d          = '0;
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
          pulse_d[idx_q] = 1'b1;
`endif
          // A re-request of the same domain goes through DONE so its enable visibly re-asserts.
          if ((pend_q != '0) && (pick != idx_q)) begin
            idx_d          = pick;
            pend_clr[pick] = 1'b1;
            clken_d[pick]  = 1'b0;
            state_d        = S_OFF;
          end else if (pend_q != '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DONE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    pend_d = (pend_q & ~pend_clr) | sw_rst_req_i;
  end

  // State and output registers with asynchronous global reset.
  always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
    if (!glb_arst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      arst_q  <= '0;
      clken_q <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
      pulse_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      arst_q  <= arst_d;
      clken_q <= clken_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
      pulse_q <= pulse_d;
`endif
    end
  end

  assign domain_arst_no  = arst_q;
  assign domain_clk_en_o = clken_q;
  assign boot_done_o     = done_q;
  assign busy_o          = busy_q;
  assign cur_domain_o    = idx_q;
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
  assign sw_rst_done_o   = pulse_q;
`endif

endmodule

// File: tb/tb_soc_ctrl_rst_seq.sv
// Scoreboard bench for soc_ctrl_rst_seq: expected output snapshots are queued per cycle
// when stimulus is driven and compared on the falling edge of that cycle.
module tb_soc_ctrl_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] arst_n, clk_en;
  logic       boot_done, busy;
  logic [1:0] cur;
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
  logic [3:0] done_pls;
  int         pulses0 = 0;
`endif

  soc_ctrl_rst_seq dut (
    .ref_clk_i      (clk),
    .glb_arst_ni    (rst_n),
    .start_i        (start),
    .sw_rst_req_i   (req),
    .domain_arst_no (arst_n),
    .domain_clk_en_o(clk_en),
    .boot_done_o    (boot_done),
    .busy_o         (busy),
    .cur_domain_o   (cur)
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
    ,
    .sw_rst_done_o  (done_pls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [11:0] v;
    string       tag;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] pk(input logic [3:0] a, input logic [3:0] c, input logic d,
                                     input logic b, input logic [1:0] cu);
    return {cu, b, d, c, a};
  endfunction

  task automatic push(input int c, input logic [11:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Compare queued expectations whose cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check_val({e.tag, "_missed"}, cyc, e.cyc);
      else check_val(e.tag, {cur, busy, boot_done, clk_en, arst_n}, {20'd0, e.v});
    end
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
    if (done_pls[0]) pulses0++;
`endif
  end

  task automatic push_boot(input int e0, input int upto, input bit pend0);
    push(e0, pk(4'h0, 4'h0, 1'b0, 1'b1, 2'd0), "boot_start");
    for (int i = 0; i < 4; i++) begin
      int r, c;
      logic [3:0] m, m1;
      logic [1:0] ci, cn;
      r  = (i + 1) * 16 + i * 8;
      c  = r + 8;
      m  = 4'((1 << i) - 1);
      m1 = 4'((1 << (i + 1)) - 1);
      ci = 2'(i);
      cn = (i < 3) ? 2'(i + 1) : 2'd3;
      if (r - 1 < upto) push(e0 + r - 1, pk(m, m, 1'b0, 1'b1, ci), $sformatf("boot_pre_arst%0d", i));
      if (r < upto)     push(e0 + r, pk(m1, m, 1'b0, 1'b1, ci), $sformatf("boot_arst%0d", i));
      if (c - 1 < upto) push(e0 + c - 1, pk(m1, m, 1'b0, 1'b1, ci), $sformatf("boot_pre_clken%0d", i));
      if (c < upto)     push(e0 + c, pk(m1, m1, (i == 3), 1'b1, cn), $sformatf("boot_clken%0d", i));
    end
    if (97 < upto) begin
      if (pend0) push(e0 + 97, pk(4'hF, 4'hE, 1'b1, 1'b1, 2'd0), "boot_then_sw0");
      else       push(e0 + 97, pk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0), "boot_idle");
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_req(input logic [3:0] v, output int t);
    @(negedge clk);
    req = v;
    t = cyc + 1;
    @(negedge clk);
    req = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e0, t;
    #12;
    check_val("reset_state", {cur, busy, boot_done, clk_en, arst_n}, 32'd0);
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
    check_val("reset_pulse", {28'd0, done_pls}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain boot
    start = 1'b1;
    e0 = cyc + 1;
    push_boot(e0, 200, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_until(e0 + 100);
    check_val("sb_empty_boot", sb.size(), 32'd0);

    // Single software reset of domain 2
    @(negedge clk);
    t = cyc + 1;
    push(t,      pk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0), "sw2_req");
    push(t + 1,  pk(4'hF, 4'hB, 1'b1, 1'b1, 2'd2), "sw2_clk_off");
    push(t + 8,  pk(4'hF, 4'hB, 1'b1, 1'b1, 2'd2), "sw2_pre_rst");
    push(t + 9,  pk(4'hB, 4'hB, 1'b1, 1'b1, 2'd2), "sw2_rst");
    push(t + 24, pk(4'hB, 4'hB, 1'b1, 1'b1, 2'd2), "sw2_hold");
    push(t + 25, pk(4'hF, 4'hB, 1'b1, 1'b1, 2'd2), "sw2_release");
    push(t + 32, pk(4'hF, 4'hB, 1'b1, 1'b1, 2'd2), "sw2_lag");
    push(t + 33, pk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0), "sw2_clk_on");
    push(t + 34, pk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0), "sw2_idle");
    req = 4'b0100;
    @(negedge clk);
    req = 4'd0;
    wait_until(t + 40);

    // Simultaneous requests for domains 1 and 3
    pulse_req(4'b1010, t);
    push(t + 1,  pk(4'hF, 4'hD, 1'b1, 1'b1, 2'd1), "sim1_clk_off");
    push(t + 9,  pk(4'hD, 4'hD, 1'b1, 1'b1, 2'd1), "sim1_rst");
    push(t + 25, pk(4'hF, 4'hD, 1'b1, 1'b1, 2'd1), "sim1_release");
    push(t + 32, pk(4'hF, 4'hD, 1'b1, 1'b1, 2'd1), "sim1_lag");
    push(t + 33, pk(4'hF, 4'h7, 1'b1, 1'b1, 2'd3), "sim3_clk_off");
    push(t + 41, pk(4'h7, 4'h7, 1'b1, 1'b1, 2'd3), "sim3_rst");
    push(t + 57, pk(4'hF, 4'h7, 1'b1, 1'b1, 2'd3), "sim3_release");
    push(t + 64, pk(4'hF, 4'h7, 1'b1, 1'b1, 2'd3), "sim3_lag");
    push(t + 65, pk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0), "sim3_clk_on");
    wait_until(t + 70);

    // Re-request of domain 0 during its own hold phase
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
    pulses0 = 0;
`endif
    pulse_req(4'b0001, t);
    push(t + 1,  pk(4'hF, 4'hE, 1'b1, 1'b1, 2'd0), "rr_clk_off");
    push(t + 9,  pk(4'hE, 4'hE, 1'b1, 1'b1, 2'd0), "rr_rst");
    push(t + 25, pk(4'hF, 4'hE, 1'b1, 1'b1, 2'd0), "rr_release");
    push(t + 33, pk(4'hF, 4'hF, 1'b1, 1'b1, 2'd0), "rr_clk_on1");
    push(t + 34, pk(4'hF, 4'hE, 1'b1, 1'b1, 2'd0), "rr_clk_off2");
    push(t + 42, pk(4'hE, 4'hE, 1'b1, 1'b1, 2'd0), "rr_rst2");
    push(t + 58, pk(4'hF, 4'hE, 1'b1, 1'b1, 2'd0), "rr_release2");
    push(t + 65, pk(4'hF, 4'hE, 1'b1, 1'b1, 2'd0), "rr_lag2");
    push(t + 66, pk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0), "rr_clk_on2");
    push(t + 67, pk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0), "rr_idle");
    wait_until(t + 13);
    req = 4'b0001;
    @(negedge clk);
    req = 4'd0;
    wait_until(t + 70);
`ifdef SOC_CTRL_RST_SEQ_DONE_PULSE_EN
    check_val("rr_done_pulses", pulses0, 32'd2);
`endif

    // Global reset, then a boot aborted at cycle 50
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("glb_reset", {cur, busy, boot_done, clk_en, arst_n}, 32'd0);
    @(negedge clk);
    start = 1'b1;
    rst_n = 1'b1;
    e0 = cyc + 1;
    push_boot(e0, 50, 1'b0);
    while (cyc < e0 + 50) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midseq_reset", {cur, busy, boot_done, clk_en, arst_n}, 32'd0);
    check_val("sb_empty_abort", sb.size(), 32'd0);

    // Reboot with start held high; request for domain 0 lands at boot cycle 30
    @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push_boot(e0, 200, 1'b1);
    push(e0 + 105, pk(4'hE, 4'hE, 1'b1, 1'b1, 2'd0), "bootreq_rst");
    push(e0 + 121, pk(4'hF, 4'hE, 1'b1, 1'b1, 2'd0), "bootreq_release");
    push(e0 + 129, pk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0), "bootreq_clk_on");
    while (cyc < e0 + 29) @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    req = 4'd0;
    wait_until(e0 + 132);
    check_val("sb_empty_end", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/soc_ctrl_rst_seq.md
Name: soc_ctrl_rst_seq

Overview:
- Upstream sequencer feeding the per-domain clock/reset delay generators.
- Produces one active-low reset and one clock-enable per SoC clock domain.
- Boot: releases domains one at a time in fixed index order, with programmable gaps.
- After boot: services per-domain software reset requests. Each request is a full enable-off, reset, reset-release, enable-on cycle for that domain only.

Parameters:
- NUM_DOMAINS, 4: number of controlled domains (>=1).
- RELEASE_GAP, 16: ref_clk_i cycles before a domain's reset release; also the software-reset hold time.
- CLK_EN_LAG, 8: ref_clk_i cycles between reset release and clock-enable assertion, and between clock-enable drop and reset assertion.

Ports:
- ref_clk_i, input, 1: reference clock, always running.
- glb_arst_ni, input, 1: global reset, asynchronous, active-low.
- start_i, input, 1: boot start; sampled high once starts boot, later values ignored.
- sw_rst_req_i, input, NUM_DOMAINS: one-cycle request pulse per domain.
- domain_arst_no, output, NUM_DOMAINS: per-domain reset, active-low; feeds arst_ni of each delay generator.
- domain_clk_en_o, output, NUM_DOMAINS: per-domain clock enable; feeds clk_en_i.
- boot_done_o, output, 1: high once all domains are released and enabled; sticky until glb reset.
- busy_o, output, 1: high while the boot or a software-reset sequence is in progress.
- cur_domain_o, output, $clog2(NUM_DOMAINS) (min 1): index of the domain being sequenced; 0 when idle.

Behaviour:
- Reset values (glb_arst_ni low): domain_arst_no=0, domain_clk_en_o=0, boot_done_o=0, busy_o=0, cur_domain_o=0, pending=0, FSM=IDLE, counter=0.
- Reset is asynchronous and may occur at any point, including mid-sequence. All outputs return to reset values immediately.
- FSM states: IDLE, B_GAP, B_LAG, DONE, S_OFF, S_HOLD, S_LAG.
- IDLE:
  - start_i high -> B_GAP, idx=0, counter cleared, busy_o=1.
- B_GAP:
  - Count to RELEASE_GAP.
  - On terminal count: domain_arst_no[idx]=1, then -> B_LAG.
- B_LAG:
  - Count to CLK_EN_LAG.
  - On terminal count: domain_clk_en_o[idx]=1.
  - If idx=NUM_DOMAINS-1 -> DONE; boot_done_o=1 in the same cycle.
  - Otherwise idx++ -> B_GAP.
- Boot timing: relative to the edge sampling start_i high (cycle 0):
  - domain_arst_no[i] rises at cycle (i+1)*RELEASE_GAP + i*CLK_EN_LAG.
  - domain_clk_en_o[i] rises CLK_EN_LAG cycles later.
- pending register:
  - Bit k is set whenever sw_rst_req_i[k] is high, in any state except glb reset.
  - Bit k is cleared in the cycle its service starts.
  - A request arriving while domain k is itself in service re-arms bit k, so domain k is serviced again afterwards.
- DONE:
  - pending != 0 -> pick the lowest set index, load idx, -> S_OFF, busy_o=1.
  - domain_clk_en_o[idx]=0 on the same edge.
  - Requests seen during boot are held and serviced on entering DONE.
- S_OFF:
  - Count CLK_EN_LAG, then domain_arst_no[idx]=0 -> S_HOLD.
- S_HOLD:
  - Count RELEASE_GAP, then domain_arst_no[idx]=1 -> S_LAG.
- S_LAG:
  - Count CLK_EN_LAG, then domain_clk_en_o[idx]=1 -> DONE, busy_o=0 (unless pending is non-zero, in which case go directly to S_OFF for the next index).
- Only the domain at idx changes during a sequence; all other domains hold their outputs.
- Counter:
  - Width $clog2(max(RELEASE_GAP,CLK_EN_LAG)+1).
  - Cleared on every state transition; no wrap.
  - RELEASE_GAP or CLK_EN_LAG = 0 is treated as 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro SOC_CTRL_RST_SEQ_DONE_PULSE_EN.
- When defined: adds output sw_rst_done_o [NUM_DOMAINS]. Bit idx pulses high for exactly one cycle, coincident with domain_clk_en_o[idx] re-asserting at the end of S_LAG.
- When undefined: the port does not exist and there is no related logic.

Test Plan:
- Boot: defaults, start_i high at cycle 0.
  - -> arst_no[0..3] rise at cycles 16/40/64/88.
  - -> clk_en[0..3] rise at cycles 24/48/72/96.
  - -> boot_done_o=1 at cycle 96, busy_o=0 at cycle 97.
- SW reset: after DONE, sw_rst_req_i=4'b0100 at cycle t.
  - -> clk_en[2]=0 at t+1, arst_no[2]=0 at t+9, arst_no[2]=1 at t+25, clk_en[2]=1 at t+33.
  - -> other domains unchanged throughout.
- Simultaneous requests: sw_rst_req_i=4'b1010 in a single cycle.
  - -> domain 1 is fully serviced, then domain 3 immediately after; busy_o stays high throughout.
- Request during boot: sw_rst_req_i=4'b0001 at cycle 30.
  - -> boot timing unchanged; domain 0 sequence starts in the cycle after boot_done_o rises.
- Mid-sequence reset: glb_arst_ni low at cycle 50 of boot.
  - -> all outputs 0 immediately.
  - -> after release, with start_i held high, arst_no[0] rises 16 cycles after the first sampling edge.
- Re-request: sw_rst_req_i[0] pulsed during S_HOLD of domain 0.
  - -> domain 0 is serviced a second time.
  - -> with SOC_CTRL_RST_SEQ_DONE_PULSE_EN defined: sw_rst_done_o[0] pulses twice.
